// File: rtl/qnigma_math_pkg.sv
// Shared widths and types for the qnigma ALU datapath and its operand load/unload paths.
// The unload block adds nbyte_t, UNLOAD_MAX_BYTES and unload_fsm_t.
package qnigma_math_pkg;

    localparam int ALU_RAM_WIDTH  = 32;
    localparam int ALU_RAM_DEPTH  = 256;
    localparam int POINT_IFC_BITS = 8;
    localparam int WORDS_PER_OPER = 9;

    localparam int RAM_W        = ALU_RAM_WIDTH;
    localparam int IFC_W        = POINT_IFC_BITS;
    localparam int PTR_W        = $clog2(ALU_RAM_DEPTH);
    localparam int IFC_PER_WRD  = RAM_W / IFC_W;
    localparam int EXT_MUX_BITS = $clog2(IFC_PER_WRD);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [RAM_W-1:0] wrd_t;
    typedef logic [5:0]       nbyte_t;

    localparam int UNLOAD_MAX_BYTES = WORDS_PER_OPER * IFC_PER_WRD;

    typedef enum logic [2:0] {IDLE, RD, WT, SER, DONE} unload_fsm_t;

endpackage

// File: rtl/qnigma_unload_ser.sv
// Word-to-byte serializer for the operand unload path: word register(s), byte mux, byte index.
// QNIGMA_UNLOAD_PREFETCH_EN adds a second (prefetch) word register.
module qnigma_unload_ser
    import qnigma_math_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [RAM_W-1:0]        word,
    input  logic                    fire,
    input  logic                    fin,
    output logic [IFC_W-1:0]        dat,
    output logic                    val,
    output logic                    wrd_end,
    output logic                    room
);

    logic [EXT_MUX_BITS-1:0] idx;
    wrd_t                    cur;
    logic                    cur_vld;
    logic                    drain;

    // The current word retires on its top byte or on the final byte of the operand.
    assign wrd_end = (idx == EXT_MUX_BITS'(IFC_PER_WRD - 1));
    assign drain   = fire && (wrd_end || fin);
    assign val     = cur_vld;
    assign dat     = cur[idx*IFC_W +: IFC_W];

    // NOTE: state is updated with <= so every register samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (drain) begin
            idx <= '0;
        end else if (fire) begin
            idx <= idx + EXT_MUX_BITS'(1);
        end
    end

`ifdef QNIGMA_UNLOAD_PREFETCH_EN
    wrd_t pf;
    logic pf_vld;

    assign room = !pf_vld;

    // NOTE: the word registers are plain flops, so they are reset too; dat_o must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= '0;
            cur_vld <= 1'b0;
            pf      <= '0;
            pf_vld  <= 1'b0;
        end else if (drain) begin
            cur     <= pf;
            cur_vld <= pf_vld;
            pf_vld  <= 1'b0;
            if (load) begin
                if (pf_vld) begin
                    pf     <= word;
                    pf_vld <= 1'b1;
                end else begin
                    cur     <= word;
                    cur_vld <= 1'b1;
                end
            end
        end else if (load) begin
            if (!cur_vld) begin
                cur     <= word;
                cur_vld <= 1'b1;
            end else begin
                pf     <= word;
                pf_vld <= 1'b1;
            end
        end
    end
`else
    assign room = !cur_vld;

    // NOTE: the word register is a plain flop, so it is reset too; dat_o must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= '0;
            cur_vld <= 1'b0;
        end else if (load) begin
            cur     <= word;
            cur_vld <= 1'b1;
        end else if (drain) begin
            cur_vld <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/qnigma_alu_unload.sv
// Streams an operand from the ALU RAM as little-endian bytes with valid/ready/last.
// Optional QNIGMA_UNLOAD_PREFETCH_EN overlaps word reads with serialization (1 byte/cycle).
module qnigma_alu_unload
    import qnigma_math_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    input  logic [5:0]        nbytes_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_rd_o,
    output logic [PTR_W-1:0]  ram_addr_o,
    input  logic [RAM_W-1:0]  ram_q_i,
    output logic [IFC_W-1:0]  dat_o,
    output logic              val_o,
    output logic              lst_o,
    input  logic              rdy_i
);

    unload_fsm_t state, state_nxt;

    ptr_t   ptr_q;
    nbyte_t n_q, nwrd_q, words_rd, byte_cnt;
    nbyte_t n_clamp, nwrd;
    logic   rd_pend;
    logic   accept, fire, last_byte, fin, wrd_end, room;

    assign n_clamp   = (nbytes_i > nbyte_t'(UNLOAD_MAX_BYTES)) ? nbyte_t'(UNLOAD_MAX_BYTES) : nbytes_i;
    assign nwrd      = nbyte_t'(({1'b0, n_clamp} + 7'(IFC_PER_WRD - 1)) >> EXT_MUX_BITS);
    assign accept    = (state == IDLE) && req_i;
    assign fire      = val_o && rdy_i;
    assign last_byte = (byte_cnt == n_q - 6'd1);
    assign fin       = fire && last_byte;
    assign lst_o     = val_o && last_byte;

    qnigma_unload_ser u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (rd_pend),
        .word    (ram_q_i),
        .fire    (fire),
        .fin     (fin),
        .dat     (dat_o),
        .val     (val_o),
        .wrd_end (wrd_end),
        .room    (room)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (req_i) state_nxt = (n_clamp == '0) ? DONE : RD;
            RD:   state_nxt = WT;
            WT:   state_nxt = SER;
            SER: begin
                if (fin) begin
                    state_nxt = DONE;
                end
`ifndef QNIGMA_UNLOAD_PREFETCH_EN
                else if (fire && wrd_end && (words_rd < nwrd_q)) begin
                    state_nxt = RD;
                end
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o   = 1'b0;
        done_o   = 1'b0;
        ram_rd_o = 1'b0;
        unique case (state)
            RD: begin
                busy_o   = 1'b1;
                ram_rd_o = room;
            end
            WT:  busy_o = 1'b1;
            SER: begin
                busy_o = 1'b1;
`ifdef QNIGMA_UNLOAD_PREFETCH_EN
                // Fetch the next word as soon as the prefetch slot is free and nothing is in flight.
                ram_rd_o = room && !rd_pend && (words_rd < nwrd_q);
`endif
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
        ram_addr_o = ram_rd_o ? (ptr_q + ptr_t'(words_rd)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            n_q      <= '0;
            nwrd_q   <= '0;
            words_rd <= '0;
            byte_cnt <= '0;
            rd_pend  <= 1'b0;
        end else begin
            rd_pend <= ram_rd_o;
            if (accept) begin
                ptr_q    <= ptr_i;
                n_q      <= n_clamp;
                nwrd_q   <= nwrd;
                words_rd <= '0;
                byte_cnt <= '0;
            end else begin
                if (ram_rd_o) words_rd <= words_rd + 6'd1;
                if (fire)     byte_cnt <= byte_cnt + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_qnigma_alu_unload.sv
// Self-checking bench for qnigma_alu_unload: RAM model plus a byte-level reference built
// straight from the operand words (LSB first, clamped length).
module tb_qnigma_alu_unload;

    localparam int MAX_B   = 36;
    localparam int ADDR_UO = 16;
    localparam int MAXC    = 600;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [7:0]  ptr_in;
    logic [5:0]  nbytes;
    logic        busy_o, done_o, ram_rd_o;
    logic [7:0]  ram_addr_o;
    logic [31:0] ram_q;
    logic [7:0]  dat_o;
    logic        val_o, lst_o;
    logic        rdy;

    logic [31:0] mem [256];

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int nreads, ndone, first_rd, first_val, last_val, last_hs, done_cyc;
    int stall_err, lst_err, busy_err, val_after;
    bit timeout;

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_rd_o) ram_q <= mem[ram_addr_o];

    qnigma_alu_unload dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .ptr_i      (ptr_in),
        .nbytes_i   (nbytes),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .ram_rd_o   (ram_rd_o),
        .ram_addr_o (ram_addr_o),
        .ram_q_i    (ram_q),
        .dat_o      (dat_o),
        .val_o      (val_o),
        .lst_o      (lst_o),
        .rdy_i      (rdy)
    );

    function automatic int n_eff(input int n);
        return (n > MAX_B) ? MAX_B : n;
    endfunction

    // Reference stream: byte i of the operand is byte (i mod 4) of word ptr + i/4.
    task automatic build_exp(input int ptr, input int n);
        logic [31:0] w;
        exp_q.delete();
        for (int i = 0; i < n_eff(n); i++) begin
            w = mem[ptr + i / 4];
            exp_q.push_back(8'(w >> (8 * (i % 4))));
        end
    endtask

    function automatic int first_bad();
        if (got_q.size() != exp_q.size()) return -2;
        for (int i = 0; i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic preset_pattern();
        for (int w = 0; w < 9; w++)
            mem[ADDR_UO + w] = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
    endtask

    // Issues one request and monitors until three cycles past done_o. Cycle 1 is the cycle after accept.
    task automatic do_xfer(input int n, input int ptr, input int rdy_pct, input bit pulse_busy);
        bit         hold;
        logic [7:0] hold_dat;
        logic       hold_lst;
        int         ne;
        ne = n_eff(n);
        build_exp(ptr, n);
        got_q.delete();
        nreads = 0; ndone = 0; first_rd = -1; first_val = -1; last_val = -1; last_hs = -1;
        done_cyc = -1; stall_err = 0; lst_err = 0; busy_err = 0; val_after = 0; timeout = 1'b0;
        hold = 1'b0; hold_dat = '0; hold_lst = 1'b0;
        @(negedge clk);
        req = 1'b1; ptr_in = 8'(ptr); nbytes = 6'(n); rdy = 1'b0;
        for (int cyc = 1; cyc <= MAXC; cyc++) begin
            @(negedge clk);
            req    = pulse_busy && (cyc == 5);
            ptr_in = 8'($urandom);
            nbytes = 6'($urandom);
            if (hold && (val_o !== 1'b1 || dat_o !== hold_dat || lst_o !== hold_lst)) stall_err++;
            if (ram_rd_o) begin
                nreads++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (busy_o && done_o) busy_err++;
            if (done_cyc >= 0 && val_o) val_after++;
            if (done_o) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (val_o) begin
                if (first_val < 0) first_val = cyc;
                last_val = cyc;
                if (lst_o !== (got_q.size() == ne - 1)) lst_err++;
            end
            rdy = ($urandom_range(99) < rdy_pct);
            if (val_o && rdy) begin
                got_q.push_back(dat_o);
                last_hs = cyc;
                hold = 1'b0;
            end else begin
                hold     = val_o;
                hold_dat = dat_o;
                hold_lst = lst_o;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        req = 1'b0;
        if (done_cyc < 0) timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; rdy = 1'b0; ptr_in = '0; nbytes = '0;
        repeat (2) @(negedge clk);
        if ({busy_o, done_o, ram_rd_o, ram_addr_o, dat_o, val_o, lst_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {busy_o, done_o, ram_rd_o, ram_addr_o, dat_o, val_o, lst_o});
        end
        checks++;
        rst_n = 1'b1;
        @(negedge clk);
        if ({busy_o, done_o, ram_rd_o, val_o} !== 4'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=0000", {busy_o, done_o, ram_rd_o, val_o});
        end
        checks++;
    endtask

    task automatic test_full32();
        int span_exp;
        preset_pattern();
        do_xfer(32, ADDR_UO, 100, 1'b0);
        if (timeout !== 1'b0) begin failures++; $display("FAIL full32_timeout got=%0d exp=0", timeout); end
        checks++;
        if (first_bad() !== -1) begin failures++; $display("FAIL full32_bytes first_bad=%0d got_n=%0d exp_n=32", first_bad(), got_q.size()); end
        checks++;
        if (nreads !== 8) begin failures++; $display("FAIL full32_reads got=%0d exp=8", nreads); end
        checks++;
        if (lst_err !== 0) begin failures++; $display("FAIL full32_lst errs=%0d exp=0", lst_err); end
        checks++;
        if (ndone !== 1 || busy_err !== 0) begin failures++; $display("FAIL full32_done got=%0d busyerr=%0d exp=1/0", ndone, busy_err); end
        checks++;
        if (first_rd !== 1 || first_val !== 3) begin failures++; $display("FAIL latency rd=%0d val=%0d exp=1/3", first_rd, first_val); end
        checks++;
        if (done_cyc !== last_hs + 1) begin failures++; $display("FAIL done_timing got=%0d exp=%0d", done_cyc, last_hs + 1); end
        checks++;
`ifdef QNIGMA_UNLOAD_PREFETCH_EN
        span_exp = 32;
`else
        span_exp = 32 + 7 * 2;
`endif
        if (last_val - first_val + 1 !== span_exp) begin
            failures++; $display("FAIL burst_span got=%0d exp=%0d", last_val - first_val + 1, span_exp);
        end
        checks++;
    endtask

    task automatic test_short(input int n, input int reads_exp);
        preset_pattern();
        do_xfer(n, ADDR_UO, 100, 1'b0);
        if (first_bad() !== -1 || timeout) begin failures++; $display("FAIL short%0d_bytes first_bad=%0d got_n=%0d exp_n=%0d", n, first_bad(), got_q.size(), n); end
        checks++;
        if (nreads !== reads_exp) begin failures++; $display("FAIL short%0d_reads got=%0d exp=%0d", n, nreads, reads_exp); end
        checks++;
        if (lst_err !== 0 || ndone !== 1) begin failures++; $display("FAIL short%0d_lst_done lsterr=%0d done=%0d exp=0/1", n, lst_err, ndone); end
        checks++;
    endtask

    task automatic test_zero();
        do_xfer(0, ADDR_UO, 100, 1'b0);
        if (nreads !== 0 || first_val !== -1) begin failures++; $display("FAIL zero_activity reads=%0d first_val=%0d exp=0/-1", nreads, first_val); end
        checks++;
        if (done_cyc !== 1 || ndone !== 1) begin failures++; $display("FAIL zero_done cyc=%0d n=%0d exp=1/1", done_cyc, ndone); end
        checks++;
    endtask

    task automatic test_backpressure();
        preset_pattern();
        do_xfer(32, ADDR_UO, 50, 1'b0);
        if (first_bad() !== -1 || timeout) begin failures++; $display("FAIL bp_bytes first_bad=%0d got_n=%0d exp_n=32", first_bad(), got_q.size()); end
        checks++;
        if (stall_err !== 0) begin failures++; $display("FAIL bp_stall_hold errs=%0d exp=0", stall_err); end
        checks++;
        if (lst_err !== 0 || ndone !== 1 || val_after !== 0) begin
            failures++; $display("FAIL bp_end lsterr=%0d done=%0d val_after=%0d exp=0/1/0", lst_err, ndone, val_after);
        end
        checks++;
    endtask

    task automatic test_random();
        int ptr, n, reads_exp;
        for (int it = 0; it < 8; it++) begin
            ptr = $urandom_range(0, 247);
            n   = (it == 0) ? 63 : $urandom_range(0, 63);
            for (int w = 0; w < 9; w++) mem[ptr + w] = $urandom;
            do_xfer(n, ptr, $urandom_range(30, 100), 1'b0);
            reads_exp = (n_eff(n) + 3) / 4;
            if (first_bad() !== -1 || timeout) begin failures++; $display("FAIL rand%0d_bytes n=%0d first_bad=%0d got_n=%0d", it, n, first_bad(), got_q.size()); end
            checks++;
            if (nreads !== reads_exp) begin failures++; $display("FAIL rand%0d_reads got=%0d exp=%0d", it, nreads, reads_exp); end
            checks++;
            if (stall_err !== 0 || lst_err !== 0 || ndone !== 1) begin
                failures++; $display("FAIL rand%0d_proto stall=%0d lst=%0d done=%0d exp=0/0/1", it, stall_err, lst_err, ndone);
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid();
        int  hs, nd;
        bit  at10;
        preset_pattern();
        hs = 0; at10 = 1'b0; nd = 0;
        @(negedge clk);
        req = 1'b1; ptr_in = 8'(ADDR_UO); nbytes = 6'd32; rdy = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (val_o) begin
                if (hs == 10) begin at10 = 1'b1; break; end
                hs++;
            end
            @(negedge clk);
        end
        if (at10 !== 1'b1 || dat_o !== 8'h0a) begin failures++; $display("FAIL rstmid_reach got=%0d/%h exp=1/0a", at10, dat_o); end
        checks++;
        rst_n = 1'b0;
        #1;
        if ({busy_o, done_o, ram_rd_o, ram_addr_o, dat_o, val_o, lst_o} !== '0) begin
            failures++; $display("FAIL rstmid_outputs got=%b exp=0", {busy_o, done_o, ram_rd_o, ram_addr_o, dat_o, val_o, lst_o});
        end
        checks++;
        for (int c = 0; c < 3; c++) begin @(negedge clk); if (done_o) nd++; end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin @(negedge clk); if (done_o) nd++; end
        if (nd !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", nd); end
        checks++;
        do_xfer(32, ADDR_UO, 100, 1'b0);
        if (first_bad() !== -1 || timeout) begin failures++; $display("FAIL rstmid_restart first_bad=%0d got_n=%0d exp_n=32", first_bad(), got_q.size()); end
        checks++;
    endtask

    task automatic test_req_busy();
        preset_pattern();
        do_xfer(32, ADDR_UO, 100, 1'b1);
        if (first_bad() !== -1 || timeout) begin failures++; $display("FAIL reqbusy_bytes first_bad=%0d got_n=%0d exp_n=32", first_bad(), got_q.size()); end
        checks++;
        if (ndone !== 1 || nreads !== 8 || val_after !== 0) begin
            failures++; $display("FAIL reqbusy_single done=%0d reads=%0d val_after=%0d exp=1/8/0", ndone, nreads, val_after);
        end
        checks++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hdead0000 | 32'(i);
        ram_q = '0;
        test_reset();
        test_full32();
        test_short(16, 4);
        test_short(6, 2);
        test_zero();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_req_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
